// File: rtl/pulse_capture.sv
// Input-capture unit: measures period and active width of a pulse train
// in clk cycles, latching each completed measurement with a valid strobe.
`timescale 1ns/1ps
module pulse_capture #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  input  logic [7:0]       control,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic [7:0]       status
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [1:0]       prime_q, prime_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] width_q, width_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic             end_seen_q, end_seen_d;
  logic             pol_q, pol_d;
  logic             valid_q, valid_d;
  logic             cap_q, cap_d;
  logic             ovf_q, ovf_d;

  logic rise, fall, edge_ok;
  logic start_edge, end_edge;
  logic cap_ev, ovf_ev;
  logic unused_ctrl;

  assign unused_ctrl = ^control[6:2];

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

  // Edges only count once the sync chain holds real samples after reset,
  // so a line already high at reset release is not seen as a rise.
  assign edge_ok    = (prime_q == 2'd3);
  assign start_edge = edge_ok & (pol_q ? fall : rise);
  assign end_edge   = edge_ok & (pol_q ? rise : fall);

  always_comb begin
    state_d    = state_q;
    prime_d    = edge_ok ? prime_q : prime_q + 2'd1;
    cnt_d      = cnt_q;
    width_d    = width_q;
    period_d   = period_q;
    high_d     = high_q;
    end_seen_d = end_seen_q;
    pol_d      = pol_q;
    valid_d    = 1'b0;
    cap_ev     = 1'b0;
    ovf_ev     = 1'b0;

    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d   = '0;
          pol_d   = control[0];
          state_d = ARM;
        end
        ARM: begin
          if (start_edge) begin
            cnt_d      = {{(WIDTH-1){1'b0}}, 1'b1};
            end_seen_d = 1'b0;
            state_d    = MEASURE;
          end
        end
        MEASURE: begin
          if (start_edge) begin
            period_d   = cnt_q;
            high_d     = width_q;
            valid_d    = 1'b1;
            cap_ev     = 1'b1;
            cnt_d      = {{(WIDTH-1){1'b0}}, 1'b1};
            end_seen_d = 1'b0;
            if (control[1]) state_d = DONE;
          end else if (cnt_q == '1) begin
            ovf_ev  = 1'b1;
            cnt_d   = '0;
            state_d = ARM;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (end_edge && !end_seen_q) begin
              width_d    = cnt_q;
              end_seen_d = 1'b1;
            end
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end

    // A same-cycle event beats the clear request.
    cap_d = cap_ev | (cap_q & ~control[7]);
    ovf_d = ovf_ev | (ovf_q & ~control[7]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      prime_q    <= 2'd0;
      cnt_q      <= '0;
      width_q    <= '0;
      period_q   <= '0;
      high_q     <= '0;
      end_seen_q <= 1'b0;
      pol_q      <= 1'b0;
      valid_q    <= 1'b0;
      cap_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_q       <= sig_in;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      prime_q    <= prime_d;
      cnt_q      <= cnt_d;
      width_q    <= width_d;
      period_q   <= period_d;
      high_q     <= high_d;
      end_seen_q <= end_seen_d;
      pol_q      <= pol_d;
      valid_q    <= valid_d;
      cap_q      <= cap_d;
      ovf_q      <= ovf_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign status    = {4'b0000, state_q == DONE, state_q == MEASURE,
                      ovf_q, cap_q};

endmodule
